reg_status_file: RTL
====================

Name: reg_status_file

Overview:
- Architectural register file plus Tomasulo register-status (Qi) table.
- Sits directly upstream of the adder reservation-station unit.
- Accepts decoded instructions, reads source operands as either a value or a producing-RS tag, and drives the issue handshake to the functional unit.
- Renames the destination register to the RS tag the unit returns, and snoops the CDB to retire tags into register values.

Parameters:
- NUM_REGS, 16, number of architectural registers.
- REG_AW, 4, register address width (log2 NUM_REGS).
- DATA_W, 32, operand/register width.
- TAG_W, 6, RS tag width; tag 0 means "no producer / valid".

Ports:
- clock  in  1  single system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  decoded instruction presented.
- instr_ready  out  1  block can accept an instruction this cycle.
- instr_op  in  6  opcode to forward.
- instr_rd  in  REG_AW  destination register.
- instr_rs  in  REG_AW  source register for A.
- instr_rt  in  REG_AW  source register for B.
- issue  out  1  issue request to functional unit.
- opcode  out  6  latched opcode.
- A  out  DATA_W  operand A value, or tag in A[TAG_W-1:0] when A_invalid.
- B  out  DATA_W  operand B value, or tag in B[TAG_W-1:0] when B_invalid.
- A_invalid  out  1  A carries a tag.
- B_invalid  out  1  B carries a tag.
- issued  in  TAG_W  RS tag accepted by the unit; 0 = not accepted.
- error  in  1  unit reports all RS busy.
- CDB_write  in  1  CDB broadcast valid.
- CDB_source  in  TAG_W  broadcasting RS tag.
- CDB_data  in  DATA_W  broadcast result.
- busy_mask  out  NUM_REGS  bit i = Qi[i] != 0.

Behaviour:
- Reset (async, any time):
  - RF[*] = 0, Qi[*] = 0, FSM = IDLE, latched instruction cleared.
  - issue = 0, opcode = 0, A = B = 0, A_invalid = B_invalid = 0, busy_mask = 0.
  - instr_ready = 1 once reset deasserts.
  - Reset mid-DRIVE abandons the instruction; no rename occurs.
- FSM states IDLE, DRIVE.
- IDLE:
  - instr_ready = 1, issue = 0.
  - On posedge with instr_valid: latch op/rd/rs/rt and move to DRIVE.
- DRIVE:
  - instr_ready = 0, issue = 1, opcode = latched op.
  - Operands are recomputed combinationally every cycle from the current RF/Qi:
    - Qi[rs] == 0: A = RF[rs], A_invalid = 0.
    - Qi[rs] != 0: A = zero-extended Qi[rs], A_invalid = 1.
    - B is derived from rt the same way.
  - issued and error are sampled at posedge.
  - issued != 0: Qi[rd] <= issued; go to IDLE. Next instruction is accepted no earlier than the following cycle, giving minimum 2 cycles/instruction.
  - issued == 0 (with or without error): stay in DRIVE and re-present operands. Retry is unbounded.
- CDB snoop (any state), at posedge when CDB_write and CDB_source != 0: every i with Qi[i] == CDB_source gets RF[i] <= CDB_data and Qi[i] <= 0.
- CDB_write with CDB_source == 0 is ignored.
- Simultaneous rename of rd and CDB retire of rd's old tag: rename wins, so Qi[rd] = issued. RF[rd] still takes CDB_data (harmless, stale until the new tag retires).
- Simultaneous rename of rd with issued equal to CDB_source of the same cycle: rename wins. The CDB does not clear the new tag.
- rd == rs or rd == rt: operands are read before the rename takes effect (old tag/value).

Optional Feature:
- Macro: CDB_BYPASS_EN.
- Defined: in DRIVE, if CDB_write and Qi[rs] == CDB_source (nonzero), A = CDB_data and A_invalid = 0 in the same cycle. B is bypassed the same way from rt.
- Undefined: the operand shows the tag that cycle and becomes valid the cycle after the CDB write.

Decomposition:
- Shared package holds:
  - TAG_W, DATA_W, and the tag constants NO_TAG = 0, adder_1..3 = 1..3.
  - Opcode constants (alu_add = 0, alu_sub = 1, alu_or = 4, alu_and = 5, alu_not = 6, alu_xor = 7).
  - FSM state enum.
- One sub-module, reg_operand_mux: given RF value, Qi, and CDB inputs, produces {value/tag, invalid}. It is instantiated twice (A, B).

Test Plan:
1. Reset, then issue add rd=3, rs=1, rt=2 with issued=1 the next cycle -> A = 0, B = 0, both valid; busy_mask = 0x0008; instr_ready returns after 2 cycles.
2. Qi[1] = 2 pending, issue rs=1 -> A_invalid = 1, A[5:0] = 2. Then CDB_write source=2 data=0x0000_00AA -> RF[1] = 0xAA, Qi[1] = 0, busy_mask bit1 clears.
3. Unit asserts error and issued = 0 for 3 cycles, then issued = 3 -> issue held 4 cycles, operands stable, Qi[rd] = 3 only after the 4th cycle.
4. CDB retires tag 1 on rd in the same cycle rd is renamed to tag 2 -> Qi[rd] = 2, busy bit stays set.
5. With CDB_BYPASS_EN, Qi[rs] = 3 and CDB_write source=3 data=0x1234 during DRIVE -> A = 0x1234, A_invalid = 0 that cycle. Without the macro -> A_invalid = 1 that cycle, 0x1234 valid next cycle.
6. Assert reset during DRIVE -> issue drops immediately, Qi all 0, no rename committed.

Source files
------------

// File: rtl/reg_status_file_pkg.sv
// Shared widths, tag/opcode constants and types for the register-status file.
// Optional CDB_BYPASS_EN forwards a same-cycle CDB result onto pending operands.
package reg_status_file_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 6;
  localparam int OP_W     = 6;

  localparam logic [TAG_W-1:0] NO_TAG  = 6'd0;
  localparam logic [TAG_W-1:0] adder_1 = 6'd1;
  localparam logic [TAG_W-1:0] adder_2 = 6'd2;
  localparam logic [TAG_W-1:0] adder_3 = 6'd3;

  localparam logic [OP_W-1:0] alu_add = 6'd0;
  localparam logic [OP_W-1:0] alu_sub = 6'd1;
  localparam logic [OP_W-1:0] alu_or  = 6'd4;
  localparam logic [OP_W-1:0] alu_and = 6'd5;
  localparam logic [OP_W-1:0] alu_not = 6'd6;
  localparam logic [OP_W-1:0] alu_xor = 6'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } instr_t;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              invalid;
  } operand_t;

  function automatic logic [DATA_W-1:0] tag_to_data(input logic [TAG_W-1:0] tag);
    return {{(DATA_W-TAG_W){1'b0}}, tag};
  endfunction

endpackage

// File: rtl/reg_operand_mux.sv
// Picks register value or producing tag for one source operand; purely combinational.
// With CDB_BYPASS_EN a matching CDB broadcast turns the operand valid in the same cycle.
module reg_operand_mux
  import reg_status_file_pkg::*;
(
  input  logic [DATA_W-1:0] rf_val_i,
  input  logic [TAG_W-1:0]  qi_i,
  input  logic              cdb_write_i,
  input  logic [TAG_W-1:0]  cdb_source_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output operand_t          opnd_o
);

  always_comb begin
    opnd_o.dat     = rf_val_i;
    opnd_o.invalid = 1'b0;
    if (qi_i != NO_TAG) begin
`ifdef CDB_BYPASS_EN
      // qi_i is nonzero here, so a tag-0 broadcast can never match.
      if (cdb_write_i && (cdb_source_i == qi_i)) begin
        opnd_o.dat = cdb_data_i;
      end else begin
        opnd_o.dat     = tag_to_data(qi_i);
        opnd_o.invalid = 1'b1;
      end
`else
      opnd_o.dat     = tag_to_data(qi_i);
      opnd_o.invalid = 1'b1;
`endif
    end
  end

`ifndef CDB_BYPASS_EN
  logic unused_cdb;
  assign unused_cdb = ^{cdb_write_i, cdb_source_i, cdb_data_i};
`endif

endmodule

// File: rtl/reg_status_file.sv
// Register file + Qi table: accepts one instruction, holds issue until the RS returns a tag (>=2 cycles/instr).
// Retries on issued==0 forever; CDB_BYPASS_EN enables same-cycle CDB forwarding in the operand muxes.
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_op,
  input  logic [REG_AW-1:0]   instr_rd,
  input  logic [REG_AW-1:0]   instr_rs,
  input  logic [REG_AW-1:0]   instr_rt,
  output logic                issue,
  output logic [OP_W-1:0]     opcode,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  output logic                A_invalid,
  output logic                B_invalid,
  input  logic [TAG_W-1:0]    issued,
  input  logic                error,
  input  logic                CDB_write,
  input  logic [TAG_W-1:0]    CDB_source,
  input  logic [DATA_W-1:0]   CDB_data,
  output logic [NUM_REGS-1:0] busy_mask
);

  state_t            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [TAG_W-1:0]  qi_q [NUM_REGS];
  logic [TAG_W-1:0]  qi_d [NUM_REGS];
  logic              rename;
  logic              cdb_hit;
  operand_t          opnd_a, opnd_b;

  // The unit's error flag needs no action: issued==0 already means retry.
  logic unused_error;
  assign unused_error = error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      rf_q    <= '{default: '0};
      qi_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rf_q    <= rf_d;
      qi_q    <= qi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rename  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = '{op: instr_op, rd: instr_rd, rs: instr_rs, rt: instr_rt};
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (issued != NO_TAG) begin
          rename  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cdb_hit = CDB_write && (CDB_source != NO_TAG);

  // CDB retire first, then rename overrides so a fresh tag is never cleared.
  always_comb begin
    rf_d = rf_q;
    qi_d = qi_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cdb_hit && (qi_q[i] == CDB_source)) begin
        rf_d[i] = CDB_data;
        qi_d[i] = NO_TAG;
      end
    end
    if (rename) begin
      qi_d[instr_q.rd] = issued;
    end
  end

  reg_operand_mux u_mux_a (
    .rf_val_i     (rf_q[instr_q.rs]),
    .qi_i         (qi_q[instr_q.rs]),
    .cdb_write_i  (CDB_write),
    .cdb_source_i (CDB_source),
    .cdb_data_i   (CDB_data),
    .opnd_o       (opnd_a)
  );

  reg_operand_mux u_mux_b (
    .rf_val_i     (rf_q[instr_q.rt]),
    .qi_i         (qi_q[instr_q.rt]),
    .cdb_write_i  (CDB_write),
    .cdb_source_i (CDB_source),
    .cdb_data_i   (CDB_data),
    .opnd_o       (opnd_b)
  );

  always_comb begin
    instr_ready = (state_q == IDLE);
    issue       = (state_q == DRIVE);
    opcode      = '0;
    A           = '0;
    B           = '0;
    A_invalid   = 1'b0;
    B_invalid   = 1'b0;
    if (state_q == DRIVE) begin
      opcode    = instr_q.op;
      A         = opnd_a.dat;
      B         = opnd_b.dat;
      A_invalid = opnd_a.invalid;
      B_invalid = opnd_b.invalid;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_mask[i] = (qi_q[i] != NO_TAG);
    end
  end

endmodule
